// File: rtl/sb_jtag_pkg.sv
// rtl/sb_jtag_pkg.sv - shared constants, state encoding and byte helpers for the RBB JTAG sequencer
package sb_jtag_pkg;

   localparam logic [7:0] CMD_READ = 8'h52;  // "R"
   localparam logic [7:0] CMD_BASE = 8'h30;  // "0"
   localparam logic [7:0] RST_BASE = 8'h72;  // "r"

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SHIFT,
      ST_POST,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // TMS navigation patterns, bit i is the TMS value of pulse i
   localparam logic [7:0] TMS_DR       = 8'b0000_0001;
   localparam int         N_DR         = 3;
   localparam logic [7:0] TMS_IR       = 8'b0000_0011;
   localparam int         N_IR         = 4;
   localparam logic [7:0] TMS_RST      = 8'b0011_1111;
   localparam int         N_RST        = 6;
   localparam logic [7:0] TMS_EXIT     = 8'b0000_0001;
   localparam int         N_EXIT       = 2;
   localparam logic [7:0] TMS_RST_POST = 8'b0000_0000;
   localparam int         N_RST_POST   = 1;

   function automatic logic [7:0] pulse_byte(input logic tck, input logic tms, input logic tdi);
      return CMD_BASE + {5'd0, tck, tms, tdi};
   endfunction

endpackage

// File: rtl/sb_jtag_rbb_pulse.sv
// rtl/sb_jtag_rbb_pulse.sv - expands one {tms,tdi,rd} pulse (or one raw reset byte) into RBB command bytes
module sb_jtag_rbb_pulse
   import sb_jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_tms,
   input  logic       in_tdi,
   input  logic       in_rd,
   input  logic       in_raw,
   input  logic [1:0] in_rst,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_data,
   output logic       rd_fire
);

   // phase 0: falling byte, 1: "R", 2: rising (last) byte
   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;
   logic [1:0] phase_q, phase_d;
   logic       tms_q, tms_d;
   logic       tdi_q, tdi_d;
   logic       rd_q, rd_d;
   logic       fire;

   assign fire      = valid_q & cmd_ready;
   assign in_ready  = ~valid_q;
   assign cmd_valid = valid_q;
   assign cmd_data  = data_q;
   assign rd_fire   = fire & rd_q & (phase_q == 2'd1);

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      phase_d = phase_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      rd_d    = rd_q;
      if (in_valid && in_ready) begin
         valid_d = 1'b1;
         tms_d   = in_tms;
         tdi_d   = in_tdi;
         if (in_raw) begin
            data_d  = RST_BASE + {6'd0, in_rst};
            phase_d = 2'd2;
            rd_d    = 1'b0;
         end else begin
            data_d  = pulse_byte(1'b0, in_tms, in_tdi);
            phase_d = 2'd0;
            rd_d    = in_rd;
         end
      end else if (fire) begin
         if (phase_q == 2'd2) begin
            valid_d = 1'b0;
         end else if (phase_q == 2'd0 && rd_q) begin
            data_d  = CMD_READ;
            phase_d = 2'd1;
         end else begin
            data_d  = pulse_byte(1'b1, tms_q, tdi_q);
            phase_d = 2'd2;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         phase_q <= 2'd0;
         tms_q   <= 1'b0;
         tdi_q   <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         phase_q <= phase_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         rd_q    <= rd_d;
      end
   end

endmodule

// File: rtl/sb_jtag_rbb_seq.sv
// rtl/sb_jtag_rbb_seq.sv - IR/DR/TAP-reset scan sequencer over an RBB byte stream (option: SB_JTAG_RBB_SEQ_TRST_EN)
module sb_jtag_rbb_seq
   import sb_jtag_pkg::*;
#(
   parameter int MAXLEN = 32,
   parameter int LW     = $clog2(MAXLEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_reset,
   input  logic              req_ir,
   input  logic [LW-1:0]     req_len,
   input  logic [MAXLEN-1:0] req_tdi,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [7:0]        cmd_data,
   input  logic              rsp_valid,
   output logic              rsp_ready,
   input  logic [7:0]        rsp_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [MAXLEN-1:0] res_tdo,
   output logic              res_err
);

   localparam int CW = (LW > 4) ? LW : 4;
`ifdef SB_JTAG_RBB_SEQ_TRST_EN
   localparam int TRST_BYTES = 2;
`else
   localparam int TRST_BYTES = 0;
`endif

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rreq_q, rreq_d;
   logic              ir_q, ir_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     issued_q, issued_d;
   logic [LW-1:0]     recvd_q, recvd_d;
   logic [MAXLEN-1:0] tdi_q, tdi_d;
   logic [MAXLEN-1:0] tdo_q, tdo_d;
   logic              err_q, err_d;
   logic              req_ready_q, req_ready_d;

   logic              p_valid, p_ready, p_tms, p_tdi, p_rd, p_raw, rd_fire;
   logic [1:0]        p_rst;
   logic [7:0]        pre_tms, post_tms;
   logic [CW-1:0]     n_pre, n_post, pre_idx, len_c;
   logic [MAXLEN-1:0] one_hot, bit_mask, sel_mask;
   logic              bad_len, req_fire, rsp_fire, rsp_bit, rsp_bad;

   assign req_ready = req_ready_q;
   assign res_valid = (state_q == ST_DONE);
   assign res_tdo   = tdo_q;
   assign res_err   = err_q;

   // replies may only be taken for reads already on the wire
   assign rsp_ready = (recvd_q < issued_q);
   assign rsp_fire  = rsp_valid & rsp_ready;
   assign rsp_bit   = (rsp_data == CMD_BASE + 8'd1);
   assign rsp_bad   = (rsp_data != CMD_BASE) && !rsp_bit;

   assign req_fire  = req_valid & req_ready_q;
   assign bad_len   = !req_reset && ((req_len == '0) || (req_len > LW'(MAXLEN)));
   assign len_c     = CW'(len_q);
   assign one_hot   = {{(MAXLEN-1){1'b0}}, 1'b1};
   assign bit_mask  = one_hot << recvd_q;
   assign sel_mask  = one_hot << cnt_q;
   assign pre_idx   = rreq_q ? (cnt_q - CW'(TRST_BYTES)) : cnt_q;

`ifdef SB_JTAG_RBB_SEQ_TRST_EN
   // "s" (trst low, srst high) then "u" (both released) ahead of the TMS reset walk
   assign p_raw = (state_q == ST_PRE) && rreq_q && (cnt_q < CW'(TRST_BYTES));
   assign p_rst = (cnt_q == '0) ? 2'b01 : 2'b11;
`else
   assign p_raw = 1'b0;
   assign p_rst = 2'b00;
`endif

   always_comb begin
      pre_tms  = TMS_DR;
      n_pre    = CW'(N_DR);
      post_tms = TMS_EXIT;
      n_post   = CW'(N_EXIT);
      if (rreq_q) begin
         pre_tms  = TMS_RST;
         n_pre    = CW'(N_RST + TRST_BYTES);
         post_tms = TMS_RST_POST;
         n_post   = CW'(N_RST_POST);
      end else if (ir_q) begin
         pre_tms  = TMS_IR;
         n_pre    = CW'(N_IR);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rreq_d   = rreq_q;
      ir_d     = ir_q;
      len_d    = len_q;
      tdi_d    = tdi_q;
      tdo_d    = tdo_q;
      err_d    = err_q;
      recvd_d  = recvd_q;
      issued_d = issued_q + {{(LW-1){1'b0}}, rd_fire};
      p_valid  = 1'b0;
      p_tms    = 1'b0;
      p_tdi    = 1'b0;
      p_rd     = 1'b0;

      if (rsp_fire) begin
         recvd_d = recvd_q + LW'(1);
         tdo_d   = rsp_bit ? (tdo_q | bit_mask) : (tdo_q & ~bit_mask);
         if (rsp_bad) err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               rreq_d   = req_reset;
               ir_d     = req_ir;
               len_d    = req_len;
               tdi_d    = req_tdi;
               cnt_d    = '0;
               issued_d = '0;
               recvd_d  = '0;
               tdo_d    = '0;
               err_d    = bad_len;
               state_d  = bad_len ? ST_DONE : ST_PRE;
            end
         end
         ST_PRE: begin
            p_valid = 1'b1;
            p_tms   = |(pre_tms & (8'd1 << pre_idx));
            if (p_ready) begin
               if (cnt_q == n_pre - CW'(1)) begin
                  cnt_d   = '0;
                  state_d = rreq_q ? ST_POST : ST_SHIFT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_SHIFT: begin
            p_valid = 1'b1;
            p_rd    = 1'b1;
            p_tdi   = |(tdi_q & sel_mask);
            p_tms   = (cnt_q == len_c - CW'(1));
            if (p_ready) begin
               if (cnt_q == len_c - CW'(1)) begin
                  cnt_d   = '0;
                  state_d = ST_POST;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_POST: begin
            p_valid = 1'b1;
            p_tms   = |(post_tms & (8'd1 << cnt_q));
            if (p_ready) begin
               if (cnt_q == n_post - CW'(1)) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            // last pulse must be fully on the wire as well as all replies in
            if (p_ready && (recvd_q == (rreq_q ? '0 : len_q))) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rreq_q      <= 1'b0;
         ir_q        <= 1'b0;
         len_q       <= '0;
         issued_q    <= '0;
         recvd_q     <= '0;
         tdi_q       <= '0;
         tdo_q       <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rreq_q      <= rreq_d;
         ir_q        <= ir_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         recvd_q     <= recvd_d;
         tdi_q       <= tdi_d;
         tdo_q       <= tdo_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
      end
   end

   sb_jtag_rbb_pulse u_pulse (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (p_valid),
      .in_ready  (p_ready),
      .in_tms    (p_tms),
      .in_tdi    (p_tdi),
      .in_rd     (p_rd),
      .in_raw    (p_raw),
      .in_rst    (p_rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .rd_fire   (rd_fire)
   );

endmodule
